// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder_pkg
// Purpose : Shared types, constants and helpers for the data-memory responder.
//           Contents: dmem_state_e (responder FSM states), DMEM_BYTES_PER_WORD,
//           dmem_lane_parity() (even-parity bit per byte lane).
// Config  : DMEM_PARITY_EN (used by the modules importing this package)
// Revision: 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  typedef enum logic {
    DMEM_IDLE  = 1'b0,
    DMEM_CLEAR = 1'b1
  } dmem_state_e;

  localparam int DMEM_BYTES_PER_WORD = 4;

  // One even-parity bit per byte lane: bit n is the XOR of word[8n+7:8n].
  function automatic logic [DMEM_BYTES_PER_WORD-1:0] dmem_lane_parity(input logic [31:0] word);
    logic [DMEM_BYTES_PER_WORD-1:0] par;
    for (int n = 0; n < DMEM_BYTES_PER_WORD; n++) begin
      par[n] = ^word[8*n +: 8];
    end
    return par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram_be.sv
`default_nettype none
// ============================================================================
// Module  : dmem_sram_be
// Purpose : DEPTH x 32 storage array with four byte-lane write enables, one
//           synchronous write port and one asynchronous (combinational) read
//           port. No reset: contents are initialised by the owner's sweep.
// Ports   : clk      - write clock
//           we_i     - per-lane write enables
//           waddr_i  - write word index
//           wdata_i  - lane-aligned write data
//           wpar_i   - per-lane parity to store      (DMEM_PARITY_EN only)
//           raddr_i  - read word index
//           rdata_o  - read data, combinational
//           rpar_o   - stored per-lane parity        (DMEM_PARITY_EN only)
// Config  : DMEM_PARITY_EN adds a DEPTH x 4 parity array alongside the data.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_sram_be
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic [DMEM_BYTES_PER_WORD-1:0] we_i,
  input  logic [AW-1:0]                  waddr_i,
  input  logic [31:0]                    wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic [DMEM_BYTES_PER_WORD-1:0] wpar_i,
  output logic [DMEM_BYTES_PER_WORD-1:0] rpar_o,
`endif
  input  logic [AW-1:0]                  raddr_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int n = 0; n < DMEM_BYTES_PER_WORD; n++) begin
      if (we_i[n]) begin
        mem[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
  end

  assign rdata_o = mem[raddr_i];

`ifdef DMEM_PARITY_EN
  logic [DMEM_BYTES_PER_WORD-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int n = 0; n < DMEM_BYTES_PER_WORD; n++) begin
      if (we_i[n]) begin
        par_mem[waddr_i][n] <= wpar_i[n];
      end
    end
  end

  assign rpar_o = par_mem[raddr_i];
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Data-memory responder for the MEM-stage data interface. Word
//           storage with byte-lane writes and a same-cycle read port, an
//           auto-clear sweep after reset / clear request, out-of-range access
//           flagging and optional per-byte parity checking.
// Ports   : clk, rst_n           - clock, asynchronous active-low reset
//           dmem_rst_i           - clear request (level), (re)starts the sweep
//           DMEM_add_i           - byte address, bits [1:0] ignored
//           DMEM_byte_mark_i     - write byte enables
//           DMEM_data_write_i    - lane-aligned write data
//           RD_mem_i / WR_mem_i  - load / store access this cycle
//           DMEM_data_o          - read data, combinational
//           busy_o               - clear sweep in progress, accesses dropped
//           addr_err_o           - access outside the mapped window
//           parity_err_o         - read parity mismatch
// Config  : DMEM_PARITY_EN enables parity storage/checking; otherwise
//           parity_err_o is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_rst_i,
  input  logic [31:0] DMEM_add_i,
  input  logic [3:0]  DMEM_byte_mark_i,
  input  logic [31:0] DMEM_data_write_i,
  input  logic        RD_mem_i,
  input  logic        WR_mem_i,
  output logic [31:0] DMEM_data_o,
  output logic        busy_o,
  output logic        addr_err_o,
  output logic        parity_err_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * DMEM_BYTES_PER_WORD);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dmem_state_e   state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [AW-1:0] idx;
  logic [31:0]   offset;
  logic          in_range;
  logic          rd_ok;
  logic          wr_ok;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_waddr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DMEM_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      DMEM_IDLE: begin
        if (dmem_rst_i) begin
          state_d   = DMEM_CLEAR;
          clr_idx_d = '0;
        end
      end
      DMEM_CLEAR: begin
        // A held clear request pins the sweep at index 0; the last word is
        // still zeroed on the cycle the FSM decides to leave.
        if (dmem_rst_i) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = DMEM_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = DMEM_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  assign busy_o = (state_q == DMEM_CLEAR);

  // -------------------------------------------------------- range check ----
  // Unsigned wrap-around makes addresses below BASE_ADDR land far above SPAN.
  assign offset   = DMEM_add_i - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign idx      = DMEM_add_i[AW+1:2];

  assign rd_ok      = RD_mem_i && !busy_o && in_range;
  assign wr_ok      = WR_mem_i && !busy_o && in_range;
  assign addr_err_o = (RD_mem_i || WR_mem_i) && !in_range;

  // ---------------------------------------------- write port muxing -------
  // The sweep owns the write port while busy; functional writes are dropped.
  assign sram_we    = busy_o ? 4'hF : (wr_ok ? DMEM_byte_mark_i : 4'h0);
  assign sram_waddr = busy_o ? clr_idx_q : idx;
  assign sram_wdata = busy_o ? 32'h0 : DMEM_data_write_i;

`ifdef DMEM_PARITY_EN
  logic [3:0] sram_wpar;
  logic [3:0] sram_rpar;

  assign sram_wpar = busy_o ? 4'h0 : dmem_lane_parity(DMEM_data_write_i);

  dmem_sram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .we_i    (sram_we),
    .waddr_i (sram_waddr),
    .wdata_i (sram_wdata),
    .wpar_i  (sram_wpar),
    .rpar_o  (sram_rpar),
    .raddr_i (idx),
    .rdata_o (sram_rdata)
  );

  assign parity_err_o = rd_ok && ((dmem_lane_parity(sram_rdata) ^ sram_rpar) != 4'h0);
`else
  dmem_sram_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .we_i    (sram_we),
    .waddr_i (sram_waddr),
    .wdata_i (sram_wdata),
    .raddr_i (idx),
    .rdata_o (sram_rdata)
  );

  assign parity_err_o = 1'b0;
`endif

  // A same-cycle read sees the pre-write contents: the array updates on the edge.
  assign DMEM_data_o = rd_ok ? sram_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Purpose : Self-checking bench for dmem_responder (DEPTH=16, BASE_ADDR=0).
//           Directed vector table, hand-written sweep/restart sequences and a
//           randomized phase checked against a word-array reference model.
// Config  : DMEM_PARITY_EN enables the parity-corruption sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_rst_i;
  logic [31:0] DMEM_add_i;
  logic [3:0]  DMEM_byte_mark_i;
  logic [31:0] DMEM_data_write_i;
  logic        RD_mem_i;
  logic        WR_mem_i;
  logic [31:0] DMEM_data_o;
  logic        busy_o;
  logic        addr_err_o;
  logic        parity_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dmem_rst_i        (dmem_rst_i),
    .DMEM_add_i        (DMEM_add_i),
    .DMEM_byte_mark_i  (DMEM_byte_mark_i),
    .DMEM_data_write_i (DMEM_data_write_i),
    .RD_mem_i          (RD_mem_i),
    .WR_mem_i          (WR_mem_i),
    .DMEM_data_o       (DMEM_data_o),
    .busy_o            (busy_o),
    .addr_err_o        (addr_err_o),
    .parity_err_o      (parity_err_o)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mark;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic int model_index(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Called just after a rising edge with the DUT idle. Drives one access,
  // checks the combinational response mid-cycle, then retires the write into
  // the model on the edge.
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0] mark,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err);
    RD_mem_i          = rd;
    WR_mem_i          = wr;
    DMEM_add_i        = addr;
    DMEM_byte_mark_i  = mark;
    DMEM_data_write_i = wdata;
    @(negedge clk);
    chk({nm, " data"}, DMEM_data_o, exp_data);
    chk({nm, " addr_err"}, {31'b0, addr_err_o}, {31'b0, exp_err});
    chk({nm, " busy"}, {31'b0, busy_o}, 32'h0);
    chk({nm, " parity_err"}, {31'b0, parity_err_o}, 32'h0);
    @(posedge clk);
    if (wr && model_in_range(addr)) begin
      for (int n = 0; n < 4; n++) begin
        if (mark[n]) model_mem[model_index(addr)][8*n +: 8] = wdata[8*n +: 8];
      end
    end
    #1;
    RD_mem_i = 1'b0;
    WR_mem_i = 1'b0;
  endtask

  // Counts cycles with busy_o high starting from the current cycle.
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (busy_o && cycles < 200) begin
      cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readout_all(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      access(nm, 1'b1, 1'b0, BASE + 32'(i * 4), 4'h0, 32'h0, model_mem[i], 1'b0);
    end
  endtask

  vec_t vecs [14];

  initial begin
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        rd, wr, inr;
    logic [31:0] exp_d;

    rst_n = 1'b0;
    dmem_rst_i = 1'b0;
    DMEM_add_i = 32'h0;
    DMEM_byte_mark_i = 4'h0;
    DMEM_data_write_i = 32'h0;
    RD_mem_i = 1'b0;
    WR_mem_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy_o}, 32'h1);
    chk("reset data", DMEM_data_o, 32'h0);
    chk("reset addr_err", {31'b0, addr_err_o}, 32'h0);
    chk("reset parity_err", {31'b0, parity_err_o}, 32'h0);

    // Sweep after release lasts DEPTH cycles
    rst_n = 1'b1;
    #1;
    count_busy(cyc);
    chk("initial sweep length", 32'(cyc), 32'(DEPTH));
    readout_all("post-sweep zero");

    // Directed vector table (executed in order, state carries over)
    vecs[0]  = '{1'b0, 1'b1, 32'h08, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h08, 4'b0100, 32'h00AA0000, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h08, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h10, 4'b1111, 32'h11111111, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h10, 4'b1111, 32'h22222222, 32'h11111111, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h22222222, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h40, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h40, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'h00, 4'b0000, 32'h12345678, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h00, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h3C, 4'b0000, 32'h0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0B, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFFC, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h08, 4'b0000, 32'h0, 32'h0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
             vecs[i].mark, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err);
    end
    // Out-of-range write must not have touched any word
    readout_all("after oob write");

    // Randomized accesses against the reference model
    for (int t = 0; t < 300; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 79));
      m  = 4'($urandom);
      d  = 32'($urandom);
      inr = model_in_range(a);
      exp_d = (rd && inr) ? model_mem[model_index(a)] : 32'h0;
      access("random", rd, wr, a, m, d, exp_d, (rd || wr) && !inr);
    end
    readout_all("after random");

    // Clear request restarted mid-sweep at clr_idx=9; busy writes to word 0
    // must be lost even after the restarted sweep has passed word 0.
    dmem_rst_i = 1'b1;
    @(posedge clk);
    #1;
    dmem_rst_i = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      dmem_rst_i        = (cyc == 9);
      RD_mem_i          = 1'b1;
      WR_mem_i          = 1'b1;
      DMEM_add_i        = 32'h0;
      DMEM_byte_mark_i  = 4'hF;
      DMEM_data_write_i = 32'hCAFEF00D;
      @(negedge clk);
      if (!busy_o) begin
        RD_mem_i = 1'b0;
        WR_mem_i = 1'b0;
        dmem_rst_i = 1'b0;
        break;
      end
      chk("read while busy", DMEM_data_o, 32'h0);
      cyc++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    chk("restarted sweep length", 32'(cyc), 32'(9 + 1 + DEPTH));
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    readout_all("after restart sweep");

    // Out-of-range flag is independent of busy; async reset takes effect at once
    access("pre-reset write", 1'b0, 1'b1, 32'h04, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0);
    RD_mem_i   = 1'b1;
    DMEM_add_i = 32'h04;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'b0, busy_o}, 32'h1);
    chk("async reset data", DMEM_data_o, 32'h0);
    DMEM_add_i = 32'h80;
    #1;
    chk("busy addr_err", {31'b0, addr_err_o}, 32'h1);
    RD_mem_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_busy(cyc);
    chk("sweep after async reset", 32'(cyc), 32'(DEPTH));
    model_mem[1] = 32'h0;
    access("word1 cleared", 1'b1, 1'b0, 32'h04, 4'h0, 32'h0, 32'h0, 1'b0);

`ifdef DMEM_PARITY_EN
    begin
      logic [3:0] pv;
      access("parity write", 1'b0, 1'b1, 32'h08, 4'hF, 32'h000000FF, 32'h0, 1'b0);
      pv = dut.u_sram.par_mem[2] ^ 4'b0001;
      force dut.u_sram.par_mem[2] = pv;
      RD_mem_i   = 1'b1;
      DMEM_add_i = 32'h08;
      @(negedge clk);
      chk("parity corrupt", {31'b0, parity_err_o}, 32'h1);
      @(posedge clk);
      #1;
      RD_mem_i = 1'b0;
      release dut.u_sram.par_mem[2];
    end
`else
    RD_mem_i   = 1'b1;
    DMEM_add_i = 32'h08;
    @(negedge clk);
    chk("parity disabled", {31'b0, parity_err_o}, 32'h0);
    @(posedge clk);
    #1;
    RD_mem_i = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
